// File: rtl/updown_timer_ctl.sv
// Loadable up/down timer with a run/stop FSM, a one-cycle terminal-count pulse,
// and one-shot or periodic reload. limit, direction and mode are latched at start.
module updown_timer_ctl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             up_down,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q_n, limit_r, limit_n;
  logic             dir_r, dir_n, mode_r, mode_n, tc_n;
  logic [WIDTH-1:0] term, init;

  // Terminal and start values come from the captured run settings only.
  assign term = dir_r ? limit_r : '0;
  assign init = dir_r ? '0 : limit_r;

  always_comb begin
    state_n = state;
    q_n     = q;
    tc_n    = 1'b0;
    limit_n = limit_r;
    dir_n   = dir_r;
    mode_n  = mode_r;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          limit_n = limit;
          dir_n   = up_down;
          mode_n  = mode;
          q_n     = up_down ? '0 : limit;
          state_n = ST_RUN;
        end else if (load) begin
          q_n     = d;
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_n = ST_IDLE;
        end else if (en) begin
          if (q == term) begin
            tc_n = 1'b1;
            if (mode_r) q_n = init;
            else        state_n = ST_DONE;
          end else begin
            q_n = dir_r ? q + WIDTH'(1) : q - WIDTH'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      q       <= '0;
      tc      <= 1'b0;
      limit_r <= '0;
      dir_r   <= 1'b0;
      mode_r  <= 1'b0;
    end else begin
      state   <= state_n;
      q       <= q_n;
      tc      <= tc_n;
      limit_r <= limit_n;
      dir_r   <= dir_n;
      mode_r  <= mode_n;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_updown_timer_ctl.sv
// Directed, table-driven bench for updown_timer_ctl (WIDTH=4).
module tb_updown_timer_ctl;

  logic       clk = 1'b0;
  logic       reset, load, up_down, en, start, stop, mode;
  logic [3:0] d, limit, q;
  logic       tc, busy, done;

  int checks = 0;
  int errors = 0;

  updown_timer_ctl #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .load(load), .d(d), .up_down(up_down),
    .en(en), .start(start), .stop(stop), .mode(mode), .limit(limit),
    .q(q), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, ld;
    logic [3:0] dv;
    logic       ud, en, st, sp, md;
    logic [3:0] lim;
    logic [3:0] eq;
    logic       etc, eb, ed;
  } vec_t;

  function automatic vec_t mk(logic rst, logic ld, logic [3:0] dv, logic ud, logic e,
                              logic st, logic sp, logic md, logic [3:0] lim,
                              logic [3:0] eq, logic etc, logic eb, logic ed);
    vec_t v;
    v.rst = rst; v.ld = ld; v.dv = dv; v.ud = ud; v.en = e; v.st = st; v.sp = sp;
    v.md = md; v.lim = lim; v.eq = eq; v.etc = etc; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic cmp(input string tag, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock once, and check the registered outputs.
  task automatic apply(input vec_t v, input string tag);
    reset = v.rst; load = v.ld; d = v.dv; up_down = v.ud; en = v.en;
    start = v.st; stop = v.sp; mode = v.md; limit = v.lim;
    @(posedge clk); #1;
    cmp({tag, ".q"},    q,    v.eq);
    cmp({tag, ".tc"},   {3'b0, tc},   {3'b0, v.etc});
    cmp({tag, ".busy"}, {3'b0, busy}, {3'b0, v.eb});
    cmp({tag, ".done"}, {3'b0, done}, {3'b0, v.ed});
  endtask

  // Shorthand for an idle-input cycle with a given enable.
  task automatic tick(input logic e, input logic [3:0] eq, input logic etc,
                      input logic eb, input logic ed, input string tag);
    apply(mk(1, 0, 0, 0, e, 0, 0, 0, 0, eq, etc, eb, ed), tag);
  endtask

  vec_t tbl[$];

  initial begin
    reset = 0; load = 0; d = 0; up_down = 0; en = 0;
    start = 0; stop = 0; mode = 0; limit = 0;

    //            rst ld d  ud en st sp md lim   q  tc b  dn
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0)); // reset
    tbl.push_back(mk(0, 1, 9, 1, 1, 1, 0, 0, 5,  0, 0, 0, 0)); // reset beats all
    tbl.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0,  9, 0, 0, 0)); // load
    tbl.push_back(mk(1, 1, 7, 1, 1, 1, 0, 0, 5,  0, 0, 1, 0)); // start beats load
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 5,  1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 5,  2, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 5,  3, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 5,  4, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 5,  5, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 5,  5, 1, 0, 1)); // tc, DONE
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 5,  5, 0, 0, 1)); // tc one cycle
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 1, 0, 5,  5, 0, 0, 1)); // stop ignored
    tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0)); // DONE load
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 3,  3, 0, 1, 0)); // down periodic
    tbl.push_back(mk(1, 1, 8, 1, 1, 1, 0, 0, 9,  2, 0, 1, 0)); // RUN ignores
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 9,  2, 0, 1, 0)); // en gap
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 9,  1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 9,  1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 9,  0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 9,  3, 1, 1, 0)); // reload
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 9,  3, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 9,  2, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0,  2, 0, 0, 0)); // stop

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Up to 15: full range with no wrap, then tc.
    apply(mk(1, 0, 0, 1, 1, 1, 0, 0, 15, 0, 0, 1, 0), "u15.start");
    for (int k = 1; k <= 15; k++) tick(1, 4'(k), 0, 1, 0, $sformatf("u15.q%0d", k));
    tick(1, 15, 1, 0, 1, "u15.tc");
    tick(1, 15, 0, 0, 1, "u15.hold");

    // Stop at q=7.
    apply(mk(1, 0, 0, 1, 1, 1, 0, 0, 15, 0, 0, 1, 0), "stp.start");
    for (int k = 1; k <= 7; k++) tick(1, 4'(k), 0, 1, 0, $sformatf("stp.q%0d", k));
    apply(mk(1, 0, 0, 1, 1, 0, 1, 0, 15, 7, 0, 0, 0), "stp.stop");
    tick(1, 7, 0, 0, 0, "stp.idle");

    // Reset at q=4 aborts with no tc.
    apply(mk(1, 0, 0, 1, 1, 1, 0, 0, 15, 0, 0, 1, 0), "rst.start");
    for (int k = 1; k <= 4; k++) tick(1, 4'(k), 0, 1, 0, $sformatf("rst.q%0d", k));
    apply(mk(0, 0, 0, 1, 1, 0, 0, 0, 15, 0, 0, 0, 0), "rst.abort");
    tick(1, 0, 0, 0, 0, "rst.after");

    // limit=0 periodic: tc every enabled cycle.
    apply(mk(1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 1, 0), "l0.start");
    for (int k = 0; k < 4; k++) tick(1, 0, 1, 1, 0, $sformatf("l0.tc%0d", k));
    apply(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), "l0.stop");

    // Down one-shot, then restart from DONE with new settings.
    apply(mk(1, 0, 0, 0, 1, 1, 0, 0, 2, 2, 0, 1, 0), "dn.start");
    tick(1, 1, 0, 1, 0, "dn.q1");
    tick(1, 0, 0, 1, 0, "dn.q0");
    tick(1, 0, 1, 0, 1, "dn.tc");
    apply(mk(1, 0, 0, 1, 1, 1, 0, 0, 3, 0, 0, 1, 0), "re.start");
    tick(1, 1, 0, 1, 0, "re.q1");
    tick(1, 2, 0, 1, 0, "re.q2");
    tick(1, 3, 0, 1, 0, "re.q3");
    tick(1, 3, 1, 0, 1, "re.tc");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_timer_ctl.md
Name: updown_timer_ctl

Overview:
- Loadable, bidirectional, parameter-width counter with a run/stop FSM, terminal-count pulse, and one-shot or periodic reload.
- It is the count-up / either-direction companion to the team's free-running 4-bit down counter.
- It serves as the general timer/prescaler primitive. Other blocks start it, poll `busy`/`done`, and consume `tc`.

Parameters:
WIDTH, 4, counter/limit/data width in bits

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-low (reset==0 at a rising clk edge resets the block)
load  input  1  parallel load of q from d (IDLE/DONE only)
d  input  WIDTH  parallel load value
up_down  input  1  direction sampled at start: 1=count up, 0=count down
en  input  1  count enable in RUN; 0 holds q
start  input  1  begin a run (IDLE/DONE only)
stop  input  1  abort a run (RUN only)
mode  input  1  sampled at start: 0=one-shot, 1=periodic
limit  input  WIDTH  terminal bound, sampled at start
q  output  WIDTH  current count (registered)
tc  output  1  registered terminal-count pulse, exactly one cycle wide
busy  output  1  1 while in RUN
done  output  1  1 while in DONE

Behaviour:
- Reset:
  - reset==0 at a posedge sets state=IDLE, q=0, tc=0, busy=0, done=0, and clears the captured limit_r/dir_r/mode_r.
  - Reset overrides every other input.
  - Reset mid-run aborts immediately and does not emit tc.
- Registered outputs: all outputs are registered. busy = (state==RUN) and done = (state==DONE), both decoded from the state register.
- tc default: tc defaults to 0 every cycle unless set by the RUN rules below.
- Terminal and start values:
  - T = limit_r when dir_r=1, or 0 when dir_r=0.
  - S = 0 when dir_r=1, or limit_r when dir_r=0.
- IDLE:
  - start=1: capture limit_r<=limit, dir_r<=up_down, mode_r<=mode; set q<=S computed from the new captures; go to RUN.
  - else load=1: q<=d, stay in IDLE.
  - else: hold.
  - start beats load when both are asserted.
- RUN, evaluated in this priority order:
  1. stop=1: go to IDLE, q holds, no tc.
  2. en=0: hold q and state.
  3. en=1 and q==T:
     - tc<=1.
     - mode_r=1: q<=S, stay in RUN.
     - mode_r=0: q holds T, go to DONE.
  4. en=1 and q!=T: q<=q+1 (dir_r=1) or q<=q-1 (dir_r=0).
- RUN input handling:
  - load and start are ignored in RUN.
  - Changes to limit/up_down/mode during RUN have no effect until the next start.
- Latency:
  - Counting up with limit=L and en held high, tc is high in the cycle after the (L+1)th enabled edge following the start edge.
  - Period in periodic mode is L+1 enabled cycles. Down counting is symmetric.
- limit==0: q==T immediately after start, so the first enabled edge produces tc (period 1, tc high every cycle in periodic mode).
- Arithmetic: q stays within [0, limit_r] during RUN, so no modulo wrap occurs. Arithmetic is unsigned WIDTH-bit.
- Loaded q outside [0, limit] is irrelevant because start always reinitialises q to S.
- DONE:
  - start=1: re-capture and enter RUN (same as IDLE).
  - else load=1: q<=d, go to IDLE.
  - else: hold q=T, done=1.
  - stop in DONE is ignored.
- FSM states: IDLE, RUN, DONE, 2-bit encoding. Any unused encoding returns to IDLE on the next edge.

Test Plan:
- Reset, load, restart: hold reset=0 for 2 cycles, release, then load=1 with d=9 -> q=0/busy=0/done=0/tc=0 during reset; q=9 after load; start restarts from S regardless of q.
- Up one-shot: start with up_down=1, mode=0, limit=5, en=1 -> q=0,1,2,3,4,5; tc=1 for exactly one cycle after the edge where q==5 is seen; state DONE, done=1, q stays 5.
- Down periodic with en gaps: up_down=0, mode=1, limit=3, en toggled 1,0,1,... -> q=3,2,1,0,3,... advancing only on en=1 edges; tc pulses once per wrap to 3; busy stays 1.
- Stop and reset mid-run:
  - up, limit=15: assert stop when q=7 -> IDLE with q=7, no tc.
  - Restart, then drive reset=0 at q=4 -> q=0, IDLE, no tc.
- Edge cases:
  - limit=0, mode=1, en=1 -> tc high every cycle and q=0.
  - WIDTH=4, limit=15, up -> reaches 15 and tc fires with no wrap glitch.
  - start and load together in IDLE -> start wins, q=S.
- DONE exits: from DONE, load=1 with d=2 -> IDLE, q=2; from DONE, start -> RUN with newly sampled limit/direction.
